// File: rtl/audio_codec_pkg.sv
// +----------------------------------------------------------------------------+
// | audio_codec_pkg                                                            |
// | WM8731 init table, state encoding and sizing constants.                    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package audio_codec_pkg;

  localparam int         NUM_REGS       = 11;
  localparam logic [7:0] CODEC_I2C_ADDR = 8'h34;
  localparam logic [3:0] LAST_IDX       = 4'(NUM_REGS - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PWR_WAIT  = 3'd1;
  localparam logic [2:0] ST_ISSUE     = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_GAP       = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;
  localparam logic [2:0] ST_ERROR     = 3'd6;

  typedef logic [15:0] codec_word_t;

  // Each word is {reg_addr[6:0], reg_data[8:0]} as sent after the chip address.
  function automatic codec_word_t init_table(input logic [3:0] idx);
    codec_word_t w;
    case (idx)
      4'd0:    w = 16'h1E00;
      4'd1:    w = 16'h0C00;
      4'd2:    w = 16'h0017;
      4'd3:    w = 16'h0217;
      4'd4:    w = 16'h0479;
      4'd5:    w = 16'h0679;
      4'd6:    w = 16'h0812;
      4'd7:    w = 16'h0A00;
      4'd8:    w = 16'h0E42;
      4'd9:    w = 16'h1000;
      4'd10:   w = 16'h1201;
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/audio_codec_init_seq_if.sv
// +----------------------------------------------------------------------------+
// | audio_codec_init_seq_if                                                    |
// | Request/done handshake between the init sequencer and the I2C write engine.|
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

interface audio_codec_init_seq_if;
  logic        i2c_req;
  logic [15:0] i2c_data;
  logic        i2c_done;
  logic        i2c_ack_ok;

  modport master (output i2c_req, output i2c_data, input i2c_done, input i2c_ack_ok);
  modport slave  (input i2c_req, input i2c_data, output i2c_done, output i2c_ack_ok);
endinterface

`default_nettype wire

// File: rtl/audio_codec_init_seq_delay.sv
// +----------------------------------------------------------------------------+
// | codec_delay_counter                                                        |
// | Load/count/expire timer shared by the power-up wait and inter-write gap.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module codec_delay_counter #(
  parameter int unsigned CNT_W = 10
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             load_i,
  input  wire logic             count_i,
  input  wire logic [CNT_W-1:0] limit_i,
  output logic                  expire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A zero limit still expires in the first cycle so the owning state lasts one cycle.
  assign expire_o = (limit_i == '0) || (cnt_q == (limit_i - CNT_W'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (count_i && !expire_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/audio_codec_init_seq.sv
// +----------------------------------------------------------------------------+
// | audio_codec_init_seq                                                       |
// | Writes the WM8731 init table through an I2C write engine after power-up.   |
// | CODEC_INIT_RETRY_EN: retry NACKed entries up to MAX_RETRY times.           |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module audio_codec_init_seq
  import audio_codec_pkg::*;
#(
  parameter int unsigned POWERUP_DELAY = 1000,
  parameter int unsigned GAP_CYCLES    = 16,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  input  wire logic              start,
  audio_codec_init_seq_if.master i2c,
  output logic [3:0]             cur_index,
  output logic                   init_done,
  output logic                   init_error
);

  localparam int unsigned MAX_WAIT = (POWERUP_DELAY > GAP_CYCLES) ? POWERUP_DELAY : GAP_CYCLES;
  localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 2);

  logic [2:0]       state_q, state_d;
  logic             req_q, req_d;
  codec_word_t      data_q, data_d;
  logic [3:0]       idx_q, idx_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             dly_load;
  logic             dly_expire;
  logic [CNT_W-1:0] dly_limit;

`ifdef CODEC_INIT_RETRY_EN
  localparam int unsigned RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RTY_W-1:0] rty_q, rty_d;
  logic             adv_q, adv_d;
`endif

  assign dly_limit = (state_q == ST_GAP) ? CNT_W'(GAP_CYCLES) : CNT_W'(POWERUP_DELAY);

  codec_delay_counter #(
    .CNT_W (CNT_W)
  ) u_delay (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_i   (dly_load),
    .count_i  ((state_q == ST_PWR_WAIT) || (state_q == ST_GAP)),
    .limit_i  (dly_limit),
    .expire_o (dly_expire)
  );

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    data_d   = data_q;
    idx_d    = idx_q;
    done_d   = done_q;
    err_d    = err_q;
    dly_load = 1'b0;
`ifdef CODEC_INIT_RETRY_EN
    rty_d    = rty_q;
    adv_d    = adv_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d  = ST_PWR_WAIT;
          idx_d    = '0;
          done_d   = 1'b0;
          err_d    = 1'b0;
          dly_load = 1'b1;
`ifdef CODEC_INIT_RETRY_EN
          rty_d    = '0;
`endif
        end
      end
      ST_PWR_WAIT: begin
        if (dly_expire) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        req_d   = 1'b1;
        data_d  = init_table(idx_q);
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (i2c.i2c_done) begin
          req_d = 1'b0;
          if (i2c.i2c_ack_ok) begin
`ifdef CODEC_INIT_RETRY_EN
            rty_d = '0;
            adv_d = 1'b1;
`endif
            if (idx_q == LAST_IDX) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d  = ST_GAP;
              dly_load = 1'b1;
            end
          end else begin
`ifdef CODEC_INIT_RETRY_EN
            // Budget spent: this NACK is the one after MAX_RETRY failed retries.
            if (rty_q == RTY_W'(MAX_RETRY)) begin
              state_d = ST_ERROR;
              err_d   = 1'b1;
            end else begin
              rty_d    = rty_q + RTY_W'(1);
              adv_d    = 1'b0;
              state_d  = ST_GAP;
              dly_load = 1'b1;
            end
`else
            state_d = ST_ERROR;
            err_d   = 1'b1;
`endif
          end
        end
      end
      ST_GAP: begin
        if (dly_expire) begin
          state_d = ST_ISSUE;
`ifdef CODEC_INIT_RETRY_EN
          if (adv_q) begin
            idx_d = idx_q + 4'd1;
          end
`else
          idx_d = idx_q + 4'd1;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef CODEC_INIT_RETRY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rty_q <= '0;
      adv_q <= 1'b0;
    end else begin
      rty_q <= rty_d;
      adv_q <= adv_d;
    end
  end
`endif

  assign i2c.i2c_req  = req_q;
  assign i2c.i2c_data = data_q;
  assign cur_index    = idx_q;
  assign init_done    = done_q;
  assign init_error   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_audio_codec_init_seq.sv
// +----------------------------------------------------------------------------+
// | tb_audio_codec_init_seq                                                    |
// | Directed bench for audio_codec_init_seq with an inline I2C engine model.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_audio_codec_init_seq;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [3:0] cur_index;
  logic       init_done;
  logic       init_error;
  int         checks;
  int         errors;

  logic [15:0] exp_tab [11] = '{16'h1E00, 16'h0C00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                                16'h0812, 16'h0A00, 16'h0E42, 16'h1000, 16'h1201};

  audio_codec_init_seq_if bus ();

  audio_codec_init_seq #(
    .POWERUP_DELAY (5),
    .GAP_CYCLES    (3),
    .MAX_RETRY     (3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .i2c        (bus),
    .cur_index  (cur_index),
    .init_done  (init_done),
    .init_error (init_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Engine model: wait for a request, hold it one cycle, then answer with ACK or NACK.
  task automatic serve(input logic ack, input logic [15:0] exp, input string tag);
    int          n;
    logic [15:0] first;
    n = 0;
    while (bus.i2c_req !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, " req"}, 32'(bus.i2c_req), 32'd1);
    check({tag, " data"}, 32'(bus.i2c_data), 32'(exp));
    first = bus.i2c_data;
    @(negedge clk);
    check({tag, " hold"}, {15'd0, bus.i2c_req, bus.i2c_data}, {15'd0, 1'b1, first});
    bus.i2c_done   = 1'b1;
    bus.i2c_ack_ok = ack;
    @(negedge clk);
    bus.i2c_done   = 1'b0;
    bus.i2c_ack_ok = 1'b0;
    check({tag, " drop"}, 32'(bus.i2c_req), 32'd0);
  endtask

  task automatic quiet(input int n, input string tag);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (bus.i2c_req !== 1'b0) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    int k;
    checks         = 0;
    errors         = 0;
    reset_n        = 1'b0;
    start          = 1'b0;
    bus.i2c_done   = 1'b0;
    bus.i2c_ack_ok = 1'b0;
    repeat (3) @(negedge clk);
    check("rst req", 32'(bus.i2c_req), 32'd0);
    check("rst data", 32'(bus.i2c_data), 32'd0);
    check("rst idx", 32'(cur_index), 32'd0);
    check("rst done", 32'(init_done), 32'd0);
    check("rst err", 32'(init_error), 32'd0);
    reset_n = 1'b1;
    quiet(5, "idle quiet");

    // Run 1: latency from start sample to first request, then a full ACKed table.
    pulse_start();
    k = 0;
    while (bus.i2c_req !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("pwr latency", 32'(k), 32'd6);
    serve(1'b1, exp_tab[0], "r1 e0");
    pulse_start();
    for (int i = 1; i < 11; i++) serve(1'b1, exp_tab[i], $sformatf("r1 e%0d", i));
    check("r1 done", 32'(init_done), 32'd1);
    check("r1 err", 32'(init_error), 32'd0);
    check("r1 idx", 32'(cur_index), 32'd10);
    quiet(20, "r1 quiet");

    // Run 2: NACK at index 3; a stray done during power-up wait must be ignored.
    pulse_start();
    check("r2 done clr", 32'(init_done), 32'd0);
    bus.i2c_done   = 1'b1;
    bus.i2c_ack_ok = 1'b0;
    @(negedge clk);
    bus.i2c_done   = 1'b0;
    for (int i = 0; i < 3; i++) serve(1'b1, exp_tab[i], $sformatf("r2 e%0d", i));
    check("r2 err pre", 32'(init_error), 32'd0);
`ifdef CODEC_INIT_RETRY_EN
    serve(1'b0, 16'h0217, "r2 try1");
    check("r2 err try1", 32'(init_error), 32'd0);
    serve(1'b0, 16'h0217, "r2 try2");
    serve(1'b1, 16'h0217, "r2 try3");
    for (int i = 4; i < 11; i++) serve(1'b1, exp_tab[i], $sformatf("r2 e%0d", i));
    check("r2 done", 32'(init_done), 32'd1);
    check("r2 err", 32'(init_error), 32'd0);

    // Run 3: four NACKs on entry 0 exhaust the retry budget.
    pulse_start();
    for (int i = 0; i < 3; i++) serve(1'b0, 16'h1E00, $sformatf("r3 nack%0d", i));
    check("r3 err pre", 32'(init_error), 32'd0);
    serve(1'b0, 16'h1E00, "r3 nack3");
    check("r3 err", 32'(init_error), 32'd1);
    check("r3 idx", 32'(cur_index), 32'd0);
    quiet(20, "r3 quiet");
`else
    serve(1'b0, 16'h0217, "r2 nack");
    check("r2 err", 32'(init_error), 32'd1);
    check("r2 idx", 32'(cur_index), 32'd3);
    check("r2 done", 32'(init_done), 32'd0);
    quiet(30, "r2 quiet");
`endif

    // Run 4: asynchronous reset while waiting on entry 5.
    pulse_start();
    for (int i = 0; i < 5; i++) serve(1'b1, exp_tab[i], $sformatf("r4 e%0d", i));
    k = 0;
    while (bus.i2c_req !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("r4 idx5", 32'(cur_index), 32'd5);
    check("r4 data5", 32'(bus.i2c_data), 32'h0679);
    #2 reset_n = 1'b0;
    #1;
    check("r4 async req", 32'(bus.i2c_req), 32'd0);
    check("r4 async idx", 32'(cur_index), 32'd0);
    check("r4 async data", 32'(bus.i2c_data), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    quiet(15, "r4 quiet");
    pulse_start();
    serve(1'b1, 16'h1E00, "r4 restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/audio_codec_init_seq.md
AUDIO_CODEC_INIT_SEQ -- requirements
Module: audio_codec_init_seq

Interface
REQ-001 SHALL have parameter POWERUP_DELAY, default 1000: clk cycles waited after start before the first write.
REQ-002 SHALL have parameter GAP_CYCLES, default 16: idle clk cycles between consecutive writes.
REQ-003 SHALL have parameter MAX_RETRY, default 3: NACK retries per entry; used only with CODEC_INIT_RETRY_EN.
REQ-004 SHALL have port clk, input, 1: system clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: one-cycle pulse; begins the sequence from IDLE, DONE or ERROR.
REQ-007 SHALL have port i2c_req, output, 1: write request to the downstream I2C write engine.
REQ-008 SHALL have port i2c_data, output, 16: {reg_addr[6:0], reg_data[8:0]}, sent MSB byte first after chip address 0x34.
REQ-009 SHALL have port i2c_done, input, 1: one-cycle pulse from the engine when a transfer ends (ACK or NACK).
REQ-010 SHALL have port i2c_ack_ok, input, 1: qualified by i2c_done; 1 means all three bytes were ACKed.
REQ-011 SHALL have port cur_index, output, 4: table index of the entry in progress.
REQ-012 SHALL have port init_done, output, 1: level; high when all entries are written.
REQ-013 SHALL have port init_error, output, 1: level; high when the sequence aborted on NACK.

Function
REQ-014 SHALL implement FSM states IDLE, PWR_WAIT, ISSUE, WAIT_DONE, GAP, DONE, ERROR.
REQ-015 SHALL move IDLE/DONE/ERROR -> PWR_WAIT on start: cur_index=0, delay counter=0, init_done=0, init_error=0.
REQ-016 SHALL stay in PWR_WAIT for exactly POWERUP_DELAY cycles, then enter ISSUE.
REQ-017 SHALL, in ISSUE, drive i2c_data=TABLE[cur_index] and i2c_req=1 on the same edge, then enter WAIT_DONE.
REQ-018 SHALL hold i2c_req=1 and i2c_data constant in WAIT_DONE until i2c_done is sampled; i2c_req SHALL fall on the following edge.
REQ-019 SHALL, on i2c_done with i2c_ack_ok=1, enter GAP if cur_index<NUM_REGS-1, otherwise enter DONE and set init_done=1.
REQ-020 SHALL, after GAP_CYCLES cycles in GAP, increment cur_index and enter ISSUE.
REQ-021 SHALL, on i2c_done with i2c_ack_ok=0, follow REQ-029/REQ-030.
REQ-022 SHALL ignore start outside IDLE/DONE/ERROR.
REQ-023 SHALL ignore i2c_done outside WAIT_DONE.
REQ-024 SHALL not wrap cur_index past NUM_REGS-1; it holds its last value in DONE.
REQ-025 SHALL make GAP_CYCLES=0 and POWERUP_DELAY=0 pass through GAP/PWR_WAIT in one cycle.

Reset
REQ-026 SHALL, on reset_n low, immediately set state=IDLE, i2c_req=0, i2c_data=0, cur_index=0, init_done=0, init_error=0 and clear all counters.
REQ-027 SHALL, on reset mid-transfer, drop i2c_req and restart only on a new start after release.
REQ-028 SHALL also reset the retry counter to 0.

Configuration
REQ-029 SHALL, with CODEC_INIT_RETRY_EN defined, on NACK increment the retry counter, enter GAP and reissue the same entry without incrementing cur_index; after MAX_RETRY failed retries, enter ERROR with init_error=1. The retry counter SHALL clear on every ACKed entry.
REQ-030 SHALL, without CODEC_INIT_RETRY_EN, enter ERROR with init_error=1 on the first NACK, with no retry counter synthesized.

Structure
REQ-031 SHALL place NUM_REGS=11, CODEC_I2C_ADDR=8'h34, the state encoding and the WM8731 table in package audio_codec_pkg.
REQ-032 SHALL use this table in order: 1E00, 0C00, 0017, 0217, 0479, 0679, 0812, 0A00, 0E42, 1000, 1201 (hex).
REQ-033 SHALL use one sub-module, codec_delay_counter (load/count/expire), shared by PWR_WAIT and GAP.

Verification
REQ-034 SHALL cover: start with an always-ACK engine model -> 11 requests with i2c_data 1E00 ... 1201 in order, then init_done=1 and init_error=0.
REQ-035 SHALL cover: POWERUP_DELAY=5 -> first i2c_req rises exactly 6 cycles after start is sampled.
REQ-036 SHALL cover: NACK on index 3, no macro -> init_error=1, cur_index=3, no further i2c_req.
REQ-037 SHALL cover: with the macro, NACK twice on index 3 then ACK -> 0217 is issued 3 times and the sequence completes with init_done=1.
REQ-038 SHALL cover: with the macro, 4 NACKs on index 0 -> init_error=1 after the 4th i2c_done.
REQ-039 SHALL cover: reset_n low while in WAIT_DONE at index 5 -> i2c_req=0 at once; the next start restarts at 1E00.
